// File: rtl/digit_compactor.sv
// digit_compactor: packs the kept 2-bit digits of a DNA word toward digit 0,
// examining LANES digits per cycle, with valid/ready on both sides.
module digit_compactor #(
  parameter int N     = 98,
  parameter int LANES = 8,
  parameter int LW    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*N-1:0]  word_in,
  input  logic [N-1:0]    keep_mask,
  input  logic [LW-1:0]   word_in_len,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  word_out,
  output logic [LW-1:0]   word_out_len,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2*N-1:0]     word_q, word_n;
  logic [N-1:0]       mask_q, mask_n;
  logic [2*N-1:0]     acc_q, acc_n;
  logic [LW-1:0]      rem_q, rem_n;
  logic [LW-1:0]      wp_q, wp_n;
  logic [LW-1:0]      len_q, len_n;
  logic               ov_q, ov_n;
  logic               rdy_q;

  logic [LW-1:0]      l_clip;
  logic [N-1:0]       len_mask;
  logic [LW-1:0]      cnt;
  logic [LW-1:0]      kept;
  logic [2*LANES-1:0] pk;
  logic [2*N-1:0]     pk_ext;

  always_comb begin
    l_clip = (word_in_len > LW'(N)) ? LW'(N) : word_in_len;
    for (int i = 0; i < N; i++) begin
      len_mask[i] = (LW'(i) < l_clip);
    end
  end

  // The working word/mask shift down each cycle, so the current chunk
  // always sits in the low LANES digits; zeros shifted in count as dropped.
  always_comb begin
    cnt = '0;
    pk  = '0;
    for (int j = 0; j < LANES; j++) begin
      if (mask_q[j]) begin
        for (int k = 0; k < LANES; k++) begin
          if (cnt == LW'(k)) begin
            pk[2*k +: 2] = word_q[2*j +: 2];
          end
        end
        cnt = cnt + LW'(1);
      end
    end
    kept = cnt;
    pk_ext = '0;
    pk_ext[2*LANES-1:0] = pk;
  end

  always_comb begin
    state_n = state;
    word_n  = word_q;
    mask_n  = mask_q;
    acc_n   = acc_q;
    rem_n   = rem_q;
    wp_n    = wp_q;
    len_n   = len_q;
    ov_n    = ov_q;
    unique case (state)
      IDLE: begin
        if (in_valid && rdy_q) begin
          word_n  = word_in;
          mask_n  = keep_mask & len_mask;
          rem_n   = l_clip;
          wp_n    = '0;
          acc_n   = '0;
          state_n = PROC;
        end
      end
      PROC: begin
        acc_n  = acc_q | (pk_ext << {wp_q, 1'b0});
        wp_n   = wp_q + kept;
        word_n = word_q >> (2*LANES);
        mask_n = mask_q >> LANES;
        if (rem_q <= LW'(LANES)) begin
          len_n   = wp_q + kept;
          ov_n    = 1'b1;
          state_n = DONE;
        end else begin
          rem_n = rem_q - LW'(LANES);
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      mask_q <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      wp_q   <= '0;
      len_q  <= '0;
      ov_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      state  <= state_n;
      word_q <= word_n;
      mask_q <= mask_n;
      acc_q  <= acc_n;
      rem_q  <= rem_n;
      wp_q   <= wp_n;
      len_q  <= len_n;
      ov_q   <= ov_n;
      rdy_q  <= (state_n == IDLE);
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = ov_q;
  assign word_out     = acc_q;
  assign word_out_len = len_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_digit_compactor.sv
// tb_digit_compactor: directed N=8/LANES=3 scenarios and a randomized
// N=98/LANES=8 regression against a software compaction model.
module tb_digit_compactor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [15:0] s_word_in, s_word_out;
  logic [7:0]  s_mask;
  logic [3:0]  s_len_in, s_len_out;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [195:0] b_word_in, b_word_out;
  logic [97:0]  b_mask;
  logic [6:0]   b_len_in, b_len_out;

  digit_compactor #(.N(8), .LANES(3), .LW(4)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .word_in(s_word_in), .keep_mask(s_mask), .word_in_len(s_len_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .word_out(s_word_out), .word_out_len(s_len_out), .busy(s_busy)
  );

  digit_compactor #(.N(98), .LANES(8), .LW(7)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .word_in(b_word_in), .keep_mask(b_mask), .word_in_len(b_len_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .word_out(b_word_out), .word_out_len(b_len_out), .busy(b_busy)
  );

  function automatic void compact(input logic [195:0] w,
                                  input logic [97:0] m,
                                  input int len, input int n,
                                  output logic [195:0] o,
                                  output int olen);
    int l;
    int k;
    l = (len > n) ? n : len;
    k = 0;
    o = '0;
    for (int i = 0; i < l; i++) begin
      if (m[i]) begin
        o[2*k +: 2] = w[2*i +: 2];
        k++;
      end
    end
    olen = k;
  endfunction

  function automatic int chunks(input int len, input int n, input int lanes);
    int l;
    l = (len > n) ? n : len;
    return (l == 0) ? 1 : (l + lanes - 1) / lanes;
  endfunction

  task automatic s_accept(input logic [15:0] w, input logic [7:0] m,
                          input logic [3:0] len);
    int t;
    t = 0;
    while (s_in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (s_in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL s_accept_timeout in_ready=%b want 1", s_in_ready);
    end
    s_word_in = w; s_mask = m; s_len_in = len; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  task automatic s_wait(output int lat);
    lat = 0;
    while (s_out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic s_release();
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic b_accept(input logic [195:0] w, input logic [97:0] m,
                          input logic [6:0] len);
    int t;
    t = 0;
    while (b_in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (b_in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout in_ready=%b want 1", b_in_ready);
    end
    b_word_in = w; b_mask = m; b_len_in = len; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctrl_s got rdy=%b ov=%b busy=%b want 0 0 0",
               s_in_ready, s_out_valid, s_busy);
    end
    checks++;
    if (s_word_out !== 16'h0 || s_len_out !== 4'h0) begin
      errors++;
      $display("FAIL rst_data_s got %h/%0d want 0/0", s_word_out, s_len_out);
    end
    checks++;
    if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0 || b_busy !== 1'b0 ||
        b_word_out !== '0 || b_len_out !== '0) begin
      errors++;
      $display("FAIL rst_b got rdy=%b ov=%b busy=%b len=%0d want all 0",
               b_in_ready, b_out_valid, b_busy, b_len_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got %b %b want 1 1",
               s_in_ready, b_in_ready);
    end
  endtask

  logic [15:0] tw [4] = '{16'hE4E4, 16'hFFFF, 16'h0002, 16'hE4E4};
  logic [7:0]  tm [4] = '{8'hAA, 8'hFF, 8'h01, 8'hFF};
  logic [3:0]  tl [4] = '{4'd8, 4'd5, 4'd12, 4'd0};
  logic [15:0] ew [4] = '{16'h00DD, 16'h03FF, 16'h0002, 16'h0000};
  logic [3:0]  el [4] = '{4'd4, 4'd5, 4'd1, 4'd0};
  int          ec [4] = '{3, 2, 3, 1};

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 4; i++) begin
      s_accept(tw[i], tm[i], tl[i]);
      s_wait(lat);
      checks++;
      if (lat != ec[i]) begin
        errors++;
        $display("FAIL dir_latency #%0d got %0d want %0d", i, lat, ec[i]);
      end
      checks++;
      if (s_word_out !== ew[i]) begin
        errors++;
        $display("FAIL dir_word #%0d got %h want %h", i, s_word_out, ew[i]);
      end
      checks++;
      if (s_len_out !== el[i]) begin
        errors++;
        $display("FAIL dir_len #%0d got %0d want %0d", i, s_len_out, el[i]);
      end
      s_release();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    s_accept(16'hE4E4, 8'hAA, 4'd8);
    s_wait(lat);
    s_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 ||
          s_word_out !== 16'h00DD || s_len_out !== 4'd4) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got ov=%b rdy=%b %h/%0d want 1 0 00dd/4",
                 i, s_out_valid, s_in_ready, s_word_out, s_len_out);
      end
    end
    s_out_ready = 1'b1;
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_bypass in_ready=%b want 0", s_in_ready);
    end
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ov=%b rdy=%b busy=%b want 0 1 0",
               s_out_valid, s_in_ready, s_busy);
    end
  endtask

  task automatic test_reset_mid_proc();
    int lat;
    s_accept(16'hE4E4, 8'hFF, 4'd8);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_word_out !== 16'h0 || s_busy !== 1'b0 ||
        s_in_ready !== 1'b0 || s_len_out !== 4'h0) begin
      errors++;
      $display("FAIL midrst got ov=%b w=%h busy=%b rdy=%b len=%0d want 0",
               s_out_valid, s_word_out, s_busy, s_in_ready, s_len_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    s_accept(16'h00C3, 8'h07, 4'd3);
    s_wait(lat);
    checks++;
    if (lat != 1 || s_word_out !== 16'h0003 || s_len_out !== 4'd3) begin
      errors++;
      $display("FAIL midrst_next got lat=%0d %h/%0d want 1 0003/3",
               lat, s_word_out, s_len_out);
    end
    s_release();
  endtask

  task automatic test_random();
    logic [223:0] rw;
    logic [127:0] rm;
    logic [195:0] w, exp_w;
    logic [97:0]  m;
    int len, exp_len, exp_c, lat, stall;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 7; i++) rw[32*i +: 32] = $urandom;
      for (int i = 0; i < 4; i++) rm[32*i +: 32] = $urandom;
      w = rw[195:0];
      m = rm[97:0];
      case ($urandom_range(0, 5))
        0: len = 0;
        1: len = 98;
        2: len = $urandom_range(99, 127);
        default: len = $urandom_range(0, 98);
      endcase
      compact(w, m, len, 98, exp_w, exp_len);
      exp_c = chunks(len, 98, 8);
      b_out_ready = ($urandom_range(0, 1) == 1);
      b_accept(w, m, 7'(len));
      lat = 0;
      while (b_out_valid !== 1'b1 && lat < 60) begin
        @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat != exp_c) begin
        errors++;
        $display("FAIL rand_latency #%0d len=%0d got %0d want %0d",
                 n, len, lat, exp_c);
      end
      checks++;
      if (b_word_out !== exp_w) begin
        errors++;
        $display("FAIL rand_word #%0d got %h want %h", n, b_word_out, exp_w);
      end
      checks++;
      if (b_len_out !== 7'(exp_len)) begin
        errors++;
        $display("FAIL rand_len #%0d got %0d want %0d", n, b_len_out, exp_len);
      end
      if (b_out_ready !== 1'b1) begin
        stall = $urandom_range(0, 3);
        repeat (stall) begin
          @(posedge clk); #1;
        end
        b_out_ready = 1'b1;
      end
      @(posedge clk); #1;
      b_out_ready = 1'b0;
    end
  endtask

  initial begin
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_word_in = '0; s_mask = '0; s_len_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_word_in = '0; b_mask = '0; b_len_in = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_proc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
